// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the FIFO pointer crossing.
// Helpers work on a wide word; callers zero-extend and truncate to their own pointer width.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } gsd_state_t;

    // Zero upper bits decode to zero, so the low SIZE bits stay correct after truncation.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer bus.
// Latency: STAGES edges from d to q.
// Backpressure: none, samples every cycle.
module gray_sync #(
    parameter int SIZE   = 4,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive side of the Gray pointer crossing: sync, decode to binary, check step legality.
// Latency: SYNC_STAGES+1 edges from a stable gray_in change to gray_sync/bin_out/adv/step_err.
// Backpressure: none; ready gates consumers until the sync pipeline holds post-reset data.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int SIZE        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] gray_in,
    input  logic            clr_err,
    output logic [SIZE-1:0] gray_sync,
    output logic [SIZE-1:0] bin_out,
    output logic            adv,
    output logic            step_err,
    output logic            err_flag,
    output logic            ready
);

    localparam int CNT_W = 3;

    logic [SIZE-1:0]  sync_q;
    logic [SIZE-1:0]  bin_new;
    logic [SIZE-1:0]  bin_inc;
    logic [SIZE-1:0]  diff;
    logic             one_bit;
    logic             inc_ok;
    logic             checks_on;
    logic             adv_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_done;
    gsd_state_t       state_q;
    gsd_state_t       state_nxt;

    gray_sync #(
        .SIZE   (SIZE),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (sync_q)
    );

    // The previous sample is the registered gray_sync/bin_out pair, so the mod-2^SIZE wrap is free.
    always_comb begin
        bin_new   = SIZE'(gray2bin(GRAY_MAX_W'(sync_q)));
        bin_inc   = bin_out + SIZE'(1);
        diff      = sync_q ^ gray_sync;
        one_bit   = (diff != '0) && ((diff & (diff - SIZE'(1))) == '0);
        inc_ok    = (bin_new == bin_inc);
        checks_on = (state_q != SETTLE);
        adv_nxt   = checks_on && one_bit && inc_ok;
        err_nxt   = checks_on && (diff != '0) && !(one_bit && inc_ok);
    end

    assign cnt_done = (cnt_q == CNT_W'(SYNC_STAGES));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            SETTLE:  if (cnt_done)             state_nxt = TRACK;
            TRACK:   if (err_nxt)              state_nxt = FAULT;
            FAULT:   if (clr_err && !err_nxt)  state_nxt = TRACK;
            default:                           state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == SETTLE && !cnt_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_sync <= '0;
            bin_out   <= '0;
            adv       <= 1'b0;
            step_err  <= 1'b0;
            err_flag  <= 1'b0;
            ready     <= 1'b0;
        end else begin
            gray_sync <= sync_q;
            bin_out   <= bin_new;
            adv       <= adv_nxt;
            step_err  <= err_nxt;
            err_flag  <= (state_nxt == FAULT);
            ready     <= (state_nxt != SETTLE);
        end
    end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (SIZE=4, SYNC_STAGES=2) with an event scoreboard.
module tb_gray_sync_decoder;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] gray_in = 4'b0000;
    logic [3:0] gray_sync;
    logic [3:0] bin_out;
    logic       adv;
    logic       step_err;
    logic       err_flag;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic       adv;
        logic       err;
        logic [3:0] bin;
        logic       flag;
        int         at;
    } exp_t;

    exp_t sb[$];

    // Gray code of binary 0..15, written out by hand.
    logic [3:0] gtab [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    gray_sync_decoder #(
        .SIZE        (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .gray_sync (gray_sync),
        .bin_out   (bin_out),
        .adv       (adv),
        .step_err  (step_err),
        .err_flag  (err_flag),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every adv/step_err pulse must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (adv || step_err) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_evt: got adv=%0d step_err=%0d bin=%0d expected no event (t=%0t)",
                         adv, step_err, bin_out, $time);
            end else begin
                e = sb.pop_front();
                chk("evt_adv",      adv,      e.adv);
                chk("evt_step_err", step_err, e.err);
                chk("evt_bin",      bin_out,  e.bin);
                chk("evt_err_flag", err_flag, e.flag);
                chk("evt_cycle",    cyc,      e.at);
            end
        end
    end

    task automatic step(input logic [3:0] g, input logic a, input logic e,
                        input logic [3:0] b, input logic f);
        @(negedge clk);
        gray_in = g;
        if (a || e) sb.push_back('{a, e, b, f, cyc + 3});
        repeat (3) @(negedge clk);
        #1;
        chk("evt_consumed", sb.size(), 0);
    endtask

    initial begin
        // 1: reset and settle
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_bin",   bin_out,   0);
        chk("rst_gsync", gray_sync, 0);
        chk("rst_ready", ready,     0);
        chk("rst_adv",   adv,       0);
        chk("rst_flag",  err_flag,  0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("settle_ready", ready, (i == 3) ? 1 : 0);
        end
        chk("settle_bin",  bin_out,  0);
        chk("settle_flag", err_flag, 0);

        // 2: first legal steps
        step(4'b0001, 1, 0, 4'd1, 0);
        step(4'b0011, 1, 0, 4'd2, 0);
        step(4'b0010, 1, 0, 4'd3, 0);
        chk("t2_gsync", gray_sync, 4'b0010);
        chk("t2_bin",   bin_out,   3);

        // 3: walk to 15 and wrap to 0
        for (int b = 4; b < 16; b++) step(gtab[b], 1, 0, 4'(b), 0);
        step(4'b0000, 1, 0, 4'd0, 0);
        chk("t3_wrap_bin", bin_out, 0);

        // 4: multi-bit jump from 0001 to 0110, then clear
        step(4'b0001, 1, 0, 4'd1, 0);
        step(4'b0110, 0, 1, 4'd4, 1);
        chk("t4_flag", err_flag, 1);
        chk("t4_bin",  bin_out,  4);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_clr_flag", err_flag, 0);
        chk("t4_ready",    ready,    1);

        // walk legally 5..15,0,1,2 to reach 0011
        for (int b = 5; b < 16; b++) step(gtab[b], 1, 0, 4'(b), 0);
        step(4'b0000, 1, 0, 4'd0, 0);
        step(4'b0001, 1, 0, 4'd1, 0);
        step(4'b0011, 1, 0, 4'd2, 0);

        // 5: backward step, then a second error coinciding with clr_err
        step(4'b0001, 0, 1, 4'd1, 1);
        chk("t5_flag", err_flag, 1);
        @(negedge clk);
        gray_in = 4'b0100;
        sb.push_back('{1'b0, 1'b1, 4'd7, 1'b1, cyc + 3});
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        chk("t5_err_wins_flag", err_flag, 1);
        chk("t5_evt_consumed",  sb.size(), 0);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t5_clr_flag", err_flag, 0);

        // 6: bring bin_out to 3 through a reset, then reset mid-operation
        rst     = 1'b1;
        gray_in = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_ready_pre", ready,   1);
        chk("t6_bin_pre",   bin_out, 3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_bin",   bin_out,   0);
        chk("t6_rst_gsync", gray_sync, 0);
        chk("t6_rst_ready", ready,     0);
        chk("t6_rst_flag",  err_flag,  0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t6_settle_ready", ready, (i == 3) ? 1 : 0);
        end
        repeat (4) @(negedge clk);
        chk("t6_bin_post",  bin_out,  3);
        chk("t6_flag_post", err_flag, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
